pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the MIPS datapath, replacing bare enable-registers between IF/ID/EX/MEM/WB. Carries a BUS_DATA-wide payload with valid/ready handshaking on both sides, a synchronous flush that inserts a bubble, and a global step-enable for the debug unit. In skid mode a second entry keeps `o_ready` registered, so no combinational path runs from `i_ready` to `o_ready`.

---
 rtl/mips_pipe_pkg.sv | 11 +
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers:
// occupancy state encoding and the default bubble (NOP) word.
package mips_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between MIPS stages: valid/ready on both sides,
// synchronous flush to a bubble, global step enable, optional skid entry.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned         BUS_DATA     = 32,
  parameter logic [BUS_DATA-1:0] BUBBLE_VALUE = BUS_DATA'(NOP_WORD),
  parameter bit                  SKID         = 1'b1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [BUS_DATA-1:0] i_data,
  output logic                o_ready,
  output logic                o_valid,
  output logic [BUS_DATA-1:0] o_data,
  input  logic                i_ready,
  output logic [1:0]          o_count
);

  logic [1:0]          state_q, state_d;
  logic [BUS_DATA-1:0] main_q, main_d;
  logic [BUS_DATA-1:0] skid_q, skid_d;
  logic                ready_s;
  logic                valid_s;
  logic                xfer_in_s;
  logic                xfer_out_s;

  assign valid_s    = (state_q != ST_EMPTY);
  assign xfer_in_s  = i_valid & ready_s & i_enable & ~i_flush;
  assign xfer_out_s = valid_s & i_ready & i_enable & ~i_flush;

  // Occupancy and data next-state; flush beats enable, reset handled in the flops.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VALUE;
    end else if (i_enable) begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in_s) begin
            state_d = ST_ONE;
            main_d  = i_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (xfer_in_s && xfer_out_s) begin
            main_d = i_data;
          end else if (xfer_in_s) begin
            // Only reachable with SKID=1: a single-entry stage is ready only when draining.
            state_d = ST_TWO;
            skid_d  = i_data;
          end else if (xfer_out_s) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (xfer_out_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VALUE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Occupancy and head-of-line payload registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      // Skid entry plus registered ready, which drops only once both entries are full.
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          ready_q <= 1'b1;
          skid_q  <= BUBBLE_VALUE;
        end else begin
          ready_q <= (state_d != ST_TWO);
          skid_q  <= skid_d;
        end
      end

      assign ready_s = ready_q;
    end else begin : g_single
      assign skid_q  = BUBBLE_VALUE;
      assign ready_s = ~valid_s | i_ready;
    end
  endgenerate

  assign o_ready = ready_s;
  assign o_valid = valid_s;
  assign o_data  = main_q;
  assign o_count = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid-mode stage checked against an occupancy model and
// FIFO of accepted beats, plus directed checks of a single-entry stage.
module tb_pipe_stage_reg;

  localparam logic [31:0] BUB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, fl, en, v, r;
  logic [31:0] d;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_count;

  logic        v0, r0;
  logic [31:0] d0;
  logic        o_ready0, o_valid0;
  logic [31:0] o_data0;
  logic [1:0]  o_count0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.BUS_DATA(32), .BUBBLE_VALUE(BUB), .SKID(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
    .i_valid(v), .i_data(d), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(r), .o_count(o_count)
  );

  pipe_stage_reg #(.BUS_DATA(32), .SKID(1'b0)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
    .i_valid(v0), .i_data(d0), .o_ready(o_ready0),
    .o_valid(o_valid0), .o_data(o_data0), .i_ready(r0), .o_count(o_count0)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] out_log[$];
  int          m_cnt   = 0;
  logic        m_ready = 1'b1;
  bit          mon_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus for the skid DUT; the model advances with the edge.
  task automatic apply(input logic rst_v, input logic fl_v, input logic en_v,
                       input logic v_v, input logic [31:0] d_v, input logic r_v);
    bit in_x, out_x;
    rst = rst_v; fl = fl_v; en = en_v; v = v_v; d = d_v; r = r_v;
    @(posedge clk);
    in_x  = v_v && m_ready && en_v && !fl_v && !rst_v;
    out_x = (m_cnt > 0) && r_v && en_v && !fl_v && !rst_v;
    if (rst_v || fl_v) begin
      m_cnt   = 0;
      m_ready = 1'b1;
      sb.delete();
    end else if (en_v) begin
      if (in_x) begin
        sb.push_back(d_v);
        m_cnt++;
      end
      if (out_x) m_cnt--;
      m_ready = (m_cnt != 2);
    end
    mon_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: checks status against the model and pops the scoreboard on each output beat.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("o_valid", 32'(o_valid), 32'(m_cnt != 0));
        chk("o_count", 32'(o_count), 32'(m_cnt));
        chk("o_ready", 32'(o_ready), 32'(m_ready));
        if (m_cnt == 0) chk("bubble", o_data, BUB);
        if (o_valid && r && en && !fl && !rst) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_empty: got %h expected no beat at %0t", o_data, $time);
          end else begin
            chk("o_data_order", o_data, sb.pop_front());
            out_log.push_back(o_data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_log[12];
    exp_log = '{32'h11, 32'h22, 32'h33, 32'h0A, 32'h0B, 32'h0C,
                32'h40, 32'h41, 32'h42, 32'h43, 32'hE1, 32'hE2};
    v0 = 1'b0; d0 = 32'h0; r0 = 1'b1;

    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Streaming at full rate.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1);
    idle(); idle();

    // Back-pressure fills the skid entry; C waits upstream until released.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0A, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0B, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1);
    idle(); idle(); idle();

    // Flush while holding two entries, then flush dropping a concurrent beat.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'hD1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'hD2, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'hD3, 1'b0);
    idle();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h77, 1'b1);
    idle();

    // Freeze mid-stream with valid and ready both high.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 1'b1);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h43, 1'b1);
    idle(); idle();

    // Freeze while stalled in the two-entry state.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'hE1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'hE2, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(); idle(); idle();

    // Reset and flush together while frozen.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'hF1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 32'hF2, 1'b1);
    idle();

    // Single-entry stage: combinational ready follows downstream ready.
    v0 = 1'b1; d0 = 32'h55; r0 = 1'b0;
    idle();
    v0 = 1'b0;
    #1;
    chk("s0_valid_full", 32'(o_valid0), 32'h1);
    chk("s0_data_full", o_data0, 32'h55);
    chk("s0_ready_stall", 32'(o_ready0), 32'h0);
    chk("s0_count_full", 32'(o_count0), 32'h1);
    r0 = 1'b1;
    #1;
    chk("s0_ready_comb", 32'(o_ready0), 32'h1);
    idle();
    #1;
    chk("s0_valid_empty", 32'(o_valid0), 32'h0);
    chk("s0_data_bubble", o_data0, 32'h0);
    chk("s0_count_empty", 32'(o_count0), 32'h0);
    v0 = 1'b1; d0 = 32'h66;
    idle();
    d0 = 32'h77;
    #1;
    chk("s0_ready_full_drain", 32'(o_ready0), 32'h1);
    idle();
    #1;
    chk("s0_data_pass", o_data0, 32'h77);
    chk("s0_count_pass", 32'(o_count0), 32'h1);
    v0 = 1'b0;
    idle(); idle();

    chk("log_size", 32'(out_log.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < out_log.size()) chk("log_beat", out_log[i], exp_log[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
